// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and load/store.
// Data wins by default; a starvation guard bounds fetch stalls and d_lock reserves the port.
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic                d_lock,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_en,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             lock_r;
    logic             resp_i;
    logic             resp_d;

    // Handshake: a requester holds req and its payload stable until gnt is high in a
    // cycle; that cycle is the transfer, and rvalid follows exactly one cycle later.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (lock_r) begin
            d_gnt = d_req;
        end else if ((starve_cnt == STARVE_LIM) && i_req) begin
            i_gnt = 1'b1;
        end else if (d_req) begin
            d_gnt = 1'b1;
        end else if (i_req) begin
            i_gnt = 1'b1;
        end
    end

    // Fetch has no write path, so write data always comes from the data side.
    always_comb begin
        m_en    = i_gnt | d_gnt;
        m_we    = d_gnt & d_we;
        m_addr  = d_gnt ? d_addr : i_addr;
        m_be    = d_gnt ? d_be : '1;
        m_wdata = d_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            lock_r     <= 1'b0;
            resp_i     <= 1'b0;
            resp_d     <= 1'b0;
        end else begin
            resp_i <= i_gnt;
            resp_d <= d_gnt;
            lock_r <= d_lock & (lock_r | d_gnt);
            // Locked cycles still count as denied fetch cycles.
            if (!i_req || i_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    assign i_rvalid = resp_i;
    assign d_rvalid = resp_d;
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a driver checks grants and memory drive each cycle and
// queues expected responses; a monitor matches rvalid/rdata against that queue.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_lock;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_en;
    logic        m_we;
    logic [3:0]  m_be;
    logic [15:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    typedef struct packed {
        logic        chk;
        logic [31:0] due;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_i_q[$];
    exp_t        exp_d_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        mon_en = 1'b0;
    logic [31:0] mem [0:511];

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory array with one-cycle read latency; word a initialised to {a, ~a}.
    initial begin
        for (int a = 0; a < 512; a++) mem[a] = {16'(a), ~16'(a)};
        m_rdata = '0;
    end

    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) mem[m_addr[8:0]][b*8 +: 8] <= m_wdata[b*8 +: 8];
            end else begin
                m_rdata <= mem[m_addr[8:0]];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // One cycle of stimulus; eig/edg are the hand-computed grants for this cycle.
    task automatic drive(input logic ir, input logic [15:0] ia, input logic dr,
                         input logic dwe, input logic [3:0] dbe, input logic [15:0] da,
                         input logic [31:0] dwd, input logic dl, input logic rs,
                         input logic eig, input logic edg, input logic [31:0] exp_rdata);
        rst = rs; i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_be = dbe;
        d_addr = da; d_wdata = dwd; d_lock = dl;
        if (!rs && eig) exp_i_q.push_back('{1'b1, 32'(cyc + 1), exp_rdata});
        if (!rs && edg) exp_d_q.push_back('{!dwe, 32'(cyc + 1), exp_rdata});
        #1;
        chk("i_gnt", 32'(i_gnt), 32'(eig));
        chk("d_gnt", 32'(d_gnt), 32'(edg));
        chk("m_en", 32'(m_en), 32'(eig | edg));
        chk("m_we", 32'(m_we), 32'(edg & dwe));
        if (eig | edg) begin
            chk("m_addr", 32'(m_addr), 32'(edg ? da : ia));
            chk("m_be", 32'(m_be), 32'(edg ? dbe : 4'hF));
            if (edg && dwe) chk("m_wdata", m_wdata, dwd);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0, 0, 0, 0, 0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic iv;
            logic dv;
            iv = (exp_i_q.size() > 0) && (exp_i_q[0].due == 32'(cyc));
            dv = (exp_d_q.size() > 0) && (exp_d_q[0].due == 32'(cyc));
            chk("i_rvalid", 32'(i_rvalid), 32'(iv));
            chk("d_rvalid", 32'(d_rvalid), 32'(dv));
            if (iv) begin
                if (i_rvalid) chk("i_rdata", i_rdata, exp_i_q[0].data);
                void'(exp_i_q.pop_front());
            end
            if (dv) begin
                if (d_rvalid && exp_d_q[0].chk) chk("d_rdata", d_rdata, exp_d_q[0].data);
                void'(exp_d_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = '0;
        d_addr = '0; d_wdata = '0; d_lock = 0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;

        // Fetch only, addresses 0..3.
        drive(1, 16'h0000, 0, 0, 4'h0, 16'h0, 32'h0, 0, 0, 1, 0, 32'h0000FFFF);
        drive(1, 16'h0001, 0, 0, 4'h0, 16'h0, 32'h0, 0, 0, 1, 0, 32'h0001FFFE);
        drive(1, 16'h0002, 0, 0, 4'h0, 16'h0, 32'h0, 0, 0, 1, 0, 32'h0002FFFD);
        drive(1, 16'h0003, 0, 0, 4'h0, 16'h0, 32'h0, 0, 0, 1, 0, 32'h0003FFFC);
        idle();

        // Contention: data wins four times, then starvation forces a fetch.
        for (int k = 0; k < 4; k++)
            drive(1, 16'h0002, 1, 0, 4'hF, 16'h0100, 32'h0, 0, 0, 0, 1, 32'h0100FEFF);
        drive(1, 16'h0002, 1, 0, 4'hF, 16'h0100, 32'h0, 0, 0, 1, 0, 32'h0002FFFD);
        drive(1, 16'h0002, 1, 0, 4'hF, 16'h0100, 32'h0, 0, 0, 0, 1, 32'h0100FEFF);
        idle();

        // Byte write to lane 1, then read back.
        drive(0, 16'h0, 1, 1, 4'b0010, 16'h0010, 32'hAABBCCDD, 0, 0, 0, 1, 32'h0);
        drive(0, 16'h0, 1, 0, 4'hF, 16'h0010, 32'h0, 0, 0, 0, 1, 32'h0010CCEF);
        idle();

        // Lock: port held for data even with starvation saturated.
        drive(1, 16'h0000, 1, 0, 4'hF, 16'h0001, 32'h0, 1, 0, 0, 1, 32'h0001FFFE);
        drive(1, 16'h0000, 1, 0, 4'hF, 16'h0002, 32'h0, 1, 0, 0, 1, 32'h0002FFFD);
        for (int k = 0; k < 3; k++)
            drive(1, 16'h0000, 0, 0, 4'hF, 16'h0000, 32'h0, 1, 0, 0, 0, 32'h0);
        drive(1, 16'h0000, 1, 0, 4'hF, 16'h0003, 32'h0, 0, 0, 0, 1, 32'h0003FFFC);
        drive(1, 16'h0000, 1, 0, 4'hF, 16'h0010, 32'h0, 0, 0, 1, 0, 32'h0000FFFF);
        drive(0, 16'h0000, 1, 0, 4'hF, 16'h0010, 32'h0, 0, 0, 0, 1, 32'h0010CCEF);
        idle();

        // Reset after a fetch grant; a locked data grant during reset must not stick.
        drive(1, 16'h0001, 0, 0, 4'h0, 16'h0, 32'h0, 0, 0, 1, 0, 32'h0001FFFE);
        drive(0, 16'h0000, 1, 0, 4'hF, 16'h0010, 32'h0, 1, 1, 0, 1, 32'h0);
        drive(1, 16'h0002, 0, 0, 4'h0, 16'h0, 32'h0, 0, 0, 1, 0, 32'h0002FFFD);
        idle();

        // Reset clears a partially built starvation count.
        for (int k = 0; k < 3; k++)
            drive(1, 16'h0003, 1, 0, 4'hF, 16'h0100, 32'h0, 0, 0, 0, 1, 32'h0100FEFF);
        drive(1, 16'h0003, 1, 0, 4'hF, 16'h0100, 32'h0, 0, 1, 0, 1, 32'h0);
        drive(1, 16'h0003, 1, 0, 4'hF, 16'h0100, 32'h0, 0, 0, 0, 1, 32'h0100FEFF);
        idle();
        idle();

        chk("i_resp_pending", 32'(exp_i_q.size()), 32'h0);
        chk("d_resp_pending", 32'(exp_d_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single-ported unified memory between two requesters: the instruction-fetch stage and the load/store stage.
- Sits between the core pipeline and the memory array.
- Grants one access per cycle and returns the read response one cycle later.
- Data accesses have priority. A starvation guard bounds fetch stalls, and a lock lets the data side hold the port for read-modify-write sequences.

Parameters:
ADDR_W, 16, word-address width into memory
DATA_W, 32, data width
STARVE_MAX, 4, consecutive denied fetch cycles after which fetch wins over data

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
i_req  in  1  fetch request
i_addr  in  ADDR_W  fetch word address
i_gnt  out  1  fetch granted this cycle (combinational)
i_rvalid  out  1  fetch read data valid
i_rdata  out  DATA_W  fetch read data
d_req  in  1  data request
d_we  in  1  data write enable
d_be  in  DATA_W/8  data byte enables
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  data write data
d_lock  in  1  keep port for data side after current grant
d_gnt  out  1  data granted this cycle (combinational)
d_rvalid  out  1  data response (read data or write ack)
d_rdata  out  DATA_W  data read data
m_en  out  1  memory access strobe
m_we  out  1  memory write
m_be  out  DATA_W/8  memory byte enables
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data, valid 1 cycle after m_en

Behaviour:
- Internal state:
  - starve_cnt: saturating, width clog2(STARVE_MAX+1).
  - lock_r: 1 bit.
  - resp_i, resp_d: 1-bit response flags.
- Reset (rst=1 at a rising edge) clears starve_cnt, lock_r, resp_i and resp_d.
  - Any in-flight response is dropped: i_rvalid=0 and d_rvalid=0 in the cycle after reset.
  - Grants remain combinational during reset cycles; the requester ignores them.
- Grant selection, evaluated each cycle in priority order:
  1. lock_r=1: d_gnt=d_req, i_gnt=0. The lock overrides starvation.
  2. starve_cnt==STARVE_MAX and i_req: i_gnt=1, d_gnt=0.
  3. d_req: d_gnt=1, i_gnt=0.
  4. i_req: i_gnt=1.
  5. Otherwise no grant.
- i_gnt and d_gnt are never both 1.
- Memory drive:
  - m_en = i_gnt | d_gnt.
  - m_we = d_gnt & d_we.
  - m_addr, m_be, m_wdata come from the winner. Fetch uses all-ones be and don't-care wdata.
  - With no grant: m_en=0 and m_we=0. Other memory outputs are don't-care.
- Responses:
  - resp_i <= i_gnt.
  - resp_d <= d_gnt (reads and writes both).
  - i_rvalid=resp_i and d_rvalid=resp_d, i.e. exactly 1 cycle after grant.
  - i_rdata=d_rdata=m_rdata; the valid flags qualify them.
  - d_rdata on a write ack is don't-care.
- starve_cnt:
  - Clears when i_gnt=1 or i_req=0.
  - Otherwise increments, saturating at STARVE_MAX. This includes cycles spent locked.
- lock_r <= d_lock & (lock_r | d_gnt).
  - Lock begins only on a granted data access with d_lock=1.
  - While locked and d_req=0, the port idles (m_en=0).
  - Dropping d_lock frees the port in the next cycle.
- Requester rules:
  - Hold req, addr, we, be and wdata stable until gnt.
  - req may drop only after the granted cycle.
  - Back-to-back grants to the same requester are allowed, giving throughput of 1 access per cycle.
- Simultaneous events:
  - A fetch granted in cycle N and a data access granted in cycle N+1 each get their own rvalid in N+1 and N+2 respectively.
  - No response queueing is needed.

Test Plan:
1. Fetch only: i_req=1 at addr 0x0000..0x0003 for 4 cycles -> i_gnt=1 each cycle, i_rvalid=1 cycles 1-4 later with i_rdata=mem[0..3], m_we=0.
2. Contention: i_req=1 and d_req=1 (read addr 0x0100) held 6 cycles -> d_gnt cycles 0-3, starve_cnt reaches 4, i_gnt in cycle 4, d_gnt cycle 5; d_rvalid/i_rvalid follow by 1 cycle.
3. Byte write: d_req=1, d_we=1, d_be=4'b0010, addr 0x0010, wdata 0xAABBCCDD -> m_we=1, m_be=4'b0010; d_rvalid=1 next cycle; a following read returns byte1=0xCC with other bytes unchanged.
4. Lock: granted data read with d_lock=1, then d_req=0 for 2 cycles with i_req=1, then d_lock=0 -> i_gnt=0 and m_en=0 while locked, starve_cnt saturates at 4, i_gnt=1 on the first cycle after d_lock drops.
5. Reset mid-operation: grant a fetch in cycle N, assert rst in cycle N+1 -> i_rvalid=0 in cycle N+2, starve_cnt=0, lock_r=0.
